// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
//   Pointer and flag controller for one side of a dual-clock FIFO. The same
//   block serves the write domain (MODE = 0) and the read domain (MODE = 1).
//   It keeps a local binary pointer, publishes it as a registered Gray code,
//   brings the opposite domain's Gray pointer across a synchroniser chain,
//   and derives full/empty, almost-full/almost-empty, the fill level and a
//   sticky overflow/underflow error.
//
// Parameters
//   ADDR_WIDTH  : RAM address width; DEPTH = 2**ADDR_WIDTH; pointers carry one
//                 extra MSB to tell full from empty.
//   SYNC_STAGES : flops in the remote-pointer synchroniser (2..4).
//   MODE        : 0 = write side (flag_o = full), 1 = read side (flag_o = empty).
//   ALMOST_TH   : write side almost when level >= DEPTH-ALMOST_TH,
//                 read side almost when level <= ALMOST_TH.
//
// Ports
//   clk_i             : local-domain clock
//   rstn_i            : asynchronous active-low reset
//   inc_i             : push (write side) / pop (read side) request
//   remote_ptr_gray_i : Gray pointer from the opposite domain (asynchronous)
//   addr_o            : RAM address, LSBs of the local binary pointer
//   ptr_gray_o        : registered Gray of the local pointer, to the other side
//   flag_o            : registered full (write side) / empty (read side)
//   almost_o          : registered almost-full / almost-empty
//   level_o           : registered entry count as seen by this domain, 0..DEPTH
//   err_o             : sticky, set when inc_i arrives while flag_o is high
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl #(
  parameter int ADDR_WIDTH  = 5,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int ALMOST_TH   = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  inc_i,
  input  logic [ADDR_WIDTH:0]   remote_ptr_gray_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [ADDR_WIDTH:0]   ptr_gray_o,
  output logic                  flag_o,
  output logic                  almost_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic                  err_o
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
  localparam logic [PW-1:0] AFULL_TH  = PW'(DEPTH - ALMOST_TH);
  localparam logic [PW-1:0] AEMPTY_TH = PW'(ALMOST_TH);
  localparam logic          RD_SIDE   = (MODE != 0);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits from the MSB down to it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] bin_ptr;
  logic [PW-1:0] rptr_sync [SYNC_STAGES];
  logic          accept;
  logic [PW-1:0] bin_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] lvl;

  // Requests are gated by the registered flag, so a blocked request can never
  // move the pointer past the opposite one.
  assign accept   = inc_i & ~flag_o;
  assign bin_next = bin_ptr + PW'(accept);

  // ---- synchroniser: remote Gray pointer, plain flop chain ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        rptr_sync[i] <= '0;
      end
    end else begin
      rptr_sync[0] <= remote_ptr_gray_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        rptr_sync[i] <= rptr_sync[i-1];
      end
    end
  end

  assign rbin = gray2bin(rptr_sync[SYNC_STAGES-1]);

  // Modular subtraction on the extended pointers gives 0..DEPTH across wraps.
  // Using bin_next lets the flag rise on the very edge that fills or drains.
  assign lvl = RD_SIDE ? (rbin - bin_next) : (bin_next - rbin);

  // ---- output stage: pointer, Gray, level and flags ----
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bin_ptr    <= '0;
      ptr_gray_o <= '0;
      level_o    <= '0;
      err_o      <= 1'b0;
      flag_o     <= RD_SIDE;
      almost_o   <= RD_SIDE;
    end else begin
      bin_ptr    <= bin_next;
      ptr_gray_o <= bin2gray(bin_next);
      level_o    <= lvl;
      if (inc_i && flag_o) begin
        err_o <= 1'b1;
      end
      if (RD_SIDE) begin
        flag_o   <= (lvl == '0);
        almost_o <= (lvl <= AEMPTY_TH);
      end else begin
        flag_o   <= (lvl == DEPTH_P);
        almost_o <= (lvl >= AFULL_TH);
      end
    end
  end

  assign addr_o = bin_ptr[ADDR_WIDTH-1:0];

endmodule
